// File: rtl/osc_tick_gen.sv
// Multi-channel programmable tick generator: each channel divides CLK by D+1 and
// emits a one-cycle TICK plus a TOGGLE square wave, with glitch-free divide updates.

module osc_tick_ch #(
    parameter int               DIV_W     = 16,
    parameter logic [DIV_W-1:0] DIV_RESET = '0
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_data,
    output logic             tick,
    output logic             toggle,
    output logic             pending
);
    logic [DIV_W-1:0] act_div;
    logic [DIV_W-1:0] shd_div;
    logic [DIV_W-1:0] cnt;
    logic             tc;

    assign tc = (cnt == act_div);

    // The active divide only changes at terminal count or while idle (cnt = 0),
    // so cnt can never run past act_div.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            act_div <= DIV_RESET;
            shd_div <= DIV_RESET;
            pending <= 1'b0;
            tick    <= 1'b0;
            toggle  <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            tick    <= 1'b0;
            toggle  <= 1'b0;
            pending <= 1'b0;
            if (wr)
                act_div <= wr_data;
            else if (pending)
                act_div <= shd_div;
        end else if (tc) begin
            cnt     <= '0;
            tick    <= 1'b1;
            toggle  <= ~toggle;
            pending <= 1'b0;
            if (wr)
                act_div <= wr_data;
            else if (pending)
                act_div <= shd_div;
        end else begin
            cnt  <= cnt + DIV_W'(1);
            tick <= 1'b0;
            if (wr) begin
                shd_div <= wr_data;
                pending <= 1'b1;
            end
        end
    end
endmodule

module osc_tick_gen #(
    parameter int          NUM_CH    = 4,
    parameter int          DIV_W     = 16,
    parameter int unsigned DIV_RESET = 999,
    localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] ENABLE,
    input  logic              WR_EN,
    input  logic [CH_W-1:0]   WR_CH,
    input  logic [DIV_W-1:0]  WR_DATA,
    output logic [NUM_CH-1:0] TICK,
    output logic [NUM_CH-1:0] TOGGLE,
    output logic [NUM_CH-1:0] PENDING
);
    typedef struct packed {
        logic             en;
        logic [CH_W-1:0]  ch;
        logic [DIV_W-1:0] data;
    } wr_req_t;

    wr_req_t           wr_req;
    logic [NUM_CH-1:0] wr_hit;
    logic [1:0]        rst_sync;
    logic              ch_rst;

    assign wr_req = '{en: WR_EN, ch: WR_CH, data: WR_DATA};

    // Assert asynchronously, release two CLK edges after RESET drops.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            rst_sync <= 2'b00;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign ch_rst = ~rst_sync[1];

    // Indices at or above NUM_CH match no channel and are dropped.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (wr_req.en && (wr_req.ch == CH_W'(i)))
                wr_hit[i] = 1'b1;
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            osc_tick_ch #(
                .DIV_W     (DIV_W),
                .DIV_RESET (DIV_W'(DIV_RESET))
            ) u_ch (
                .CLK     (CLK),
                .rst     (ch_rst),
                .en      (ENABLE[i]),
                .wr      (wr_hit[i]),
                .wr_data (wr_req.data),
                .tick    (TICK[i]),
                .toggle  (TOGGLE[i]),
                .pending (PENDING[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_osc_tick_gen.sv
// Bench for osc_tick_gen: tick-time scoreboard for period checks plus a
// step table for short multi-cycle write/enable sequences.

module tb_osc_tick_gen;
    localparam int NUM_CH = 3;
    localparam int DIV_W  = 16;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [NUM_CH-1:0] ENABLE;
    logic              WR_EN;
    logic [1:0]        WR_CH;
    logic [DIV_W-1:0]  WR_DATA;
    logic [NUM_CH-1:0] TICK, TOGGLE, PENDING;

    osc_tick_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DIV_RESET(999)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .ENABLE  (ENABLE),
        .WR_EN   (WR_EN),
        .WR_CH   (WR_CH),
        .WR_DATA (WR_DATA),
        .TICK    (TICK),
        .TOGGLE  (TOGGLE),
        .PENDING (PENDING)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int   cyc;
        logic tog;
    } exp_t;

    typedef struct {
        logic [2:0]  en;
        logic        wr;
        logic [1:0]  ch;
        logic [15:0] data;
        int          n;
        logic [2:0]  tick;
        logic [2:0]  tog;
        logic [2:0]  pend;
    } vec_t;

    exp_t       exp_q[NUM_CH][$];
    vec_t       tbl[18];
    int         checks = 0;
    int         fails  = 0;
    int         cyc    = 0;
    logic [2:0] mon_on = 3'b000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: advance to the sampling edge, then score any ticks.
    task automatic step();
        @(negedge CLK);
        cyc++;
        for (int c = 0; c < NUM_CH; c++) begin
            if (mon_on[c] && TICK[c]) begin
                if (exp_q[c].size() == 0)
                    chk($sformatf("unexpected_tick_ch%0d", c), 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = exp_q[c].pop_front();
                    chk($sformatf("tick_time_ch%0d", c), cyc, e.cyc);
                    chk($sformatf("tick_toggle_ch%0d", c), {31'd0, TOGGLE[c]}, {31'd0, e.tog});
                end
            end
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic push(input int c, input int first, input int period, input int n, input logic tog0);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            int   kk;
            kk    = k;
            e.cyc = first + k * period;
            e.tog = tog0 ^ kk[0];
            exp_q[c].push_back(e);
        end
    endtask

    task automatic wait_drain(input int c, input int budget);
        int b;
        b = 0;
        while (exp_q[c].size() != 0 && b < budget) begin
            step();
            b++;
        end
        chk($sformatf("ticks_missing_ch%0d", c), exp_q[c].size(), 0);
    endtask

    task automatic wr(input int c, input int d);
        WR_EN   = 1'b1;
        WR_CH   = c[1:0];
        WR_DATA = d[15:0];
        step();
        WR_EN   = 1'b0;
    endtask

    initial begin
        int base;

        // en, wr, ch, data, n, exp tick, exp toggle, exp pending
        tbl[0]  = '{3'b000, 1'b1, 2'd2, 16'd0, 1, 3'b000, 3'b000, 3'b000};
        tbl[1]  = '{3'b100, 1'b0, 2'd0, 16'd0, 1, 3'b100, 3'b100, 3'b000};
        tbl[2]  = '{3'b100, 1'b0, 2'd0, 16'd0, 1, 3'b100, 3'b000, 3'b000};
        tbl[3]  = '{3'b100, 1'b0, 2'd0, 16'd0, 1, 3'b100, 3'b100, 3'b000};
        tbl[4]  = '{3'b000, 1'b0, 2'd0, 16'd0, 1, 3'b000, 3'b000, 3'b000};
        tbl[5]  = '{3'b010, 1'b0, 2'd0, 16'd0, 1, 3'b000, 3'b000, 3'b000};
        tbl[6]  = '{3'b010, 1'b1, 2'd1, 16'd1, 1, 3'b000, 3'b000, 3'b010};
        tbl[7]  = '{3'b000, 1'b0, 2'd0, 16'd0, 1, 3'b000, 3'b000, 3'b000};
        tbl[8]  = '{3'b010, 1'b0, 2'd0, 16'd0, 1, 3'b000, 3'b000, 3'b000};
        tbl[9]  = '{3'b010, 1'b0, 2'd0, 16'd0, 1, 3'b010, 3'b010, 3'b000};
        tbl[10] = '{3'b010, 1'b1, 2'd1, 16'd5, 1, 3'b000, 3'b010, 3'b010};
        tbl[11] = '{3'b010, 1'b1, 2'd1, 16'd2, 1, 3'b010, 3'b000, 3'b000};
        tbl[12] = '{3'b010, 1'b1, 2'd1, 16'd6, 1, 3'b000, 3'b000, 3'b010};
        tbl[13] = '{3'b010, 1'b1, 2'd1, 16'd3, 1, 3'b000, 3'b000, 3'b010};
        tbl[14] = '{3'b010, 1'b0, 2'd0, 16'd0, 1, 3'b010, 3'b010, 3'b000};
        tbl[15] = '{3'b010, 1'b0, 2'd0, 16'd0, 3, 3'b000, 3'b010, 3'b000};
        tbl[16] = '{3'b010, 1'b0, 2'd0, 16'd0, 1, 3'b010, 3'b000, 3'b000};
        tbl[17] = '{3'b000, 1'b0, 2'd0, 16'd0, 1, 3'b000, 3'b000, 3'b000};

        RESET   = 1'b1;
        ENABLE  = 3'b001;
        WR_EN   = 1'b0;
        WR_CH   = 2'd0;
        WR_DATA = 16'd0;
        steps(3);
        chk("rst_tick", {29'd0, TICK}, 32'd0);
        chk("rst_toggle", {29'd0, TOGGLE}, 32'd0);
        chk("rst_pending", {29'd0, PENDING}, 32'd0);

        // Default divide after reset release: 1000-cycle period, 2000-cycle toggle.
        mon_on = 3'b001;
        base   = cyc;
        push(0, base + 1002, 1000, 4, 1'b1);
        RESET = 1'b0;
        wait_drain(0, 4200);
        ENABLE = 3'b000;
        step();

        // Deferred divide update on ch1.
        wr(1, 9);
        chk("dis_wr_pend", {29'd0, PENDING}, 32'd0);
        mon_on = 3'b011;
        base   = cyc;
        ENABLE = 3'b010;
        push(1, base + 10, 10, 1, 1'b1);
        push(1, base + 15, 5, 2, 1'b0);
        steps(3);
        wr(1, 4);
        chk("pend_set", {29'd0, PENDING}, 32'b010);
        steps(5);
        chk("pend_hold", {29'd0, PENDING}, 32'b010);
        step();
        chk("pend_clr", {29'd0, PENDING}, 32'd0);
        wait_drain(1, 30);
        ENABLE = 3'b000;
        step();

        // Write landing on terminal count of ch0, then disable mid-period.
        wr(0, 9);
        base   = cyc;
        ENABLE = 3'b001;
        push(0, base + 10, 10, 1, 1'b1);
        push(0, base + 13, 3, 2, 1'b0);
        steps(9);
        wr(0, 2);
        chk("tc_wr_pend", {29'd0, PENDING}, 32'd0);
        wait_drain(0, 20);
        step();
        chk("tog_before_dis", {31'd0, TOGGLE[0]}, 32'd1);
        ENABLE = 3'b000;
        step();
        chk("dis_tick", {31'd0, TICK[0]}, 32'd0);
        chk("dis_toggle", {31'd0, TOGGLE[0]}, 32'd0);

        // Out-of-range write while restarting: no effect on ch0 divide or pending.
        base    = cyc;
        ENABLE  = 3'b001;
        push(0, base + 3, 3, 2, 1'b1);
        wr(3, 7);
        chk("oor_pend", {29'd0, PENDING}, 32'd0);
        wait_drain(0, 20);
        ENABLE = 3'b000;
        step();
        mon_on = 3'b000;

        for (int i = 0; i < 18; i++) begin
            ENABLE  = tbl[i].en;
            WR_EN   = tbl[i].wr;
            WR_CH   = tbl[i].ch;
            WR_DATA = tbl[i].data;
            step();
            WR_EN = 1'b0;
            steps(tbl[i].n - 1);
            chk($sformatf("tbl%0d_tick", i), {29'd0, TICK}, {29'd0, tbl[i].tick});
            chk($sformatf("tbl%0d_toggle", i), {29'd0, TOGGLE}, {29'd0, tbl[i].tog});
            chk($sformatf("tbl%0d_pending", i), {29'd0, PENDING}, {29'd0, tbl[i].pend});
        end

        // Reset mid-count with a pending write discards both.
        ENABLE = 3'b010;
        step();
        wr(1, 8);
        chk("pre_rst_pend", {29'd0, PENDING}, 32'b010);
        #2 RESET = 1'b1;
        #1 chk("async_rst_outs", {23'd0, TICK, TOGGLE, PENDING}, 32'd0);
        step();
        mon_on = 3'b010;
        base   = cyc;
        push(1, base + 1002, 1000, 1, 1'b1);
        RESET = 1'b0;
        step();
        chk("post_rst_pend", {29'd0, PENDING}, 32'd0);
        wait_drain(1, 1100);
        ENABLE = 3'b000;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
